// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and helpers for the shift-and-add multiplier controller
package mult_pkg;

  // Controller states; all four encodings are in use
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    CALC = 2'b10,
    DONE = 2'b11
  } state_e;

  // Width of the iteration index; never narrower than one bit
  function automatic int iter_width(input int width);
    if (width <= 2) return 1;
    return $clog2(width);
  endfunction

endpackage

// File: rtl/mult_controlunit_if.sv
// rtl/mult_controlunit_if.sv - control/handshake bundle between controller and multiplier datapath
interface mult_controlunit_if
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic                          inputdata_ready;
  logic                          multiplier_lsb;
  logic                          result_ack;
  logic                          loaddata;
  logic                          add_en;
  logic                          shift_en;
  logic                          busy;
  logic                          done;
  logic [iter_width(WIDTH)-1:0]  iter;

  // Controller side: consumes requests and datapath status, drives commands
  modport master (
    input  inputdata_ready,
    input  multiplier_lsb,
    input  result_ack,
    output loaddata,
    output add_en,
    output shift_en,
    output busy,
    output done,
    output iter
  );

  // Datapath / environment side
  modport slave (
    output inputdata_ready,
    output multiplier_lsb,
    output result_ack,
    input  loaddata,
    input  add_en,
    input  shift_en,
    input  busy,
    input  done,
    input  iter
  );

endinterface

// File: rtl/mult_controlunit_iter_counter.sv
// rtl/mult_controlunit_iter_counter.sv - iteration counter with clear, enable and last-iteration flag
module iter_counter
  import mult_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = iter_width(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          last
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Clear has priority so LOAD always starts the sequence from zero
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register, asynchronously cleared
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/mult_controlunit.sv
// rtl/mult_controlunit.sv - sequencing FSM for a WIDTH-bit shift-and-add multiplier
module mult_controlunit
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  mult_controlunit_if.master  bus
);

  localparam int CW = iter_width(WIDTH);

  state_e        state_q;
  state_e        state_d;
  logic          cnt_clear;
  logic          cnt_en;
  logic          cnt_last;
  logic [CW-1:0] cnt_value;

  // Counter is zeroed during LOAD and frozen on the final CALC step so iter
  // keeps showing WIDTH-1 once the result is ready
  assign cnt_clear = (state_q == LOAD);
  assign cnt_en    = (state_q == CALC) && !cnt_last;

  iter_counter #(
    .WIDTH (WIDTH)
  ) u_iter_counter (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .en    (cnt_en),
    .count (cnt_value),
    .last  (cnt_last)
  );

  // State register; reset forces IDLE asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; requests are only looked at in IDLE and DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.inputdata_ready) state_d = LOAD;
      end
      LOAD: begin
        state_d = CALC;
      end
      CALC: begin
        if (cnt_last) state_d = DONE;
      end
      DONE: begin
        if (bus.result_ack) begin
          state_d = bus.inputdata_ready ? LOAD : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode; add_en follows the multiplier LSB only while calculating
  always_comb begin
    bus.loaddata = 1'b0;
    bus.add_en   = 1'b0;
    bus.shift_en = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    case (state_q)
      LOAD: begin
        bus.loaddata = 1'b1;
        bus.busy     = 1'b1;
      end
      CALC: begin
        bus.busy     = 1'b1;
        bus.shift_en = 1'b1;
        bus.add_en   = bus.multiplier_lsb;
      end
      DONE: begin
        bus.done     = 1'b1;
      end
      default: begin
        bus.loaddata = 1'b0;
      end
    endcase
  end

  assign bus.iter = cnt_value;

endmodule

// File: tb/tb_mult_controlunit.sv
// tb/tb_mult_controlunit.sv - directed self-checking bench for mult_controlunit
module tb_mult_controlunit;
  import mult_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   n;

  always #5 clk = ~clk;

  mult_controlunit_if #(.WIDTH(8)) bus8 ();
  mult_controlunit_if #(.WIDTH(2)) bus2 ();

  mult_controlunit #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
  mult_controlunit #(.WIDTH(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  // Datapath model for the 8-bit instance
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic [15:0] mcand;
  logic [15:0] acc;
  logic [7:0]  mplier;

  assign bus8.multiplier_lsb = mplier[0];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
    end else if (bus8.loaddata) begin
      mcand  <= {8'h00, op_a};
      mplier <= op_b;
      acc    <= '0;
    end else if (bus8.shift_en) begin
      if (bus8.add_en) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  // {loaddata, add_en, shift_en, busy, done}
  logic [4:0] o8;
  logic [4:0] o2;
  assign o8 = {bus8.loaddata, bus8.add_en, bus8.shift_en, bus8.busy, bus8.done};
  assign o2 = {bus2.loaddata, bus2.add_en, bus2.shift_en, bus2.busy, bus2.done};

  logic [7:0] exp_add;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus8.inputdata_ready = 1'b0;
    bus8.result_ack      = 1'b0;
    bus2.inputdata_ready = 1'b0;
    bus2.result_ack      = 1'b0;
    bus2.multiplier_lsb  = 1'b0;
    op_a    = 8'h0D;
    op_b    = 8'hA5;
    exp_add = 8'b1010_0101;

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      bus8.inputdata_ready = 1'($urandom_range(0, 1));
      bus8.result_ack      = 1'($urandom_range(0, 1));
      bus2.inputdata_ready = 1'($urandom_range(0, 1));
      bus2.result_ack      = 1'($urandom_range(0, 1));
      bus2.multiplier_lsb  = 1'($urandom_range(0, 1));
      tick();
      chk("reset_outs8", 32'(o8), 32'h0);
      chk("reset_iter8", 32'(bus8.iter), 32'h0);
      chk("reset_outs2", 32'(o2), 32'h0);
    end
    bus8.inputdata_ready = 1'b0;
    bus8.result_ack      = 1'b0;
    bus2.inputdata_ready = 1'b0;
    bus2.result_ack      = 1'b0;
    bus2.multiplier_lsb  = 1'b0;
    reset = 1'b1;
    tick();
    chk("idle_outs", 32'(o8), 32'h0);

    // Acknowledge in IDLE does nothing
    bus8.result_ack = 1'b1;
    tick();
    bus8.result_ack = 1'b0;
    chk("ack_in_idle", 32'(o8), 32'h0);
    tick();
    chk("ack_in_idle_after", 32'(o8), 32'h0);

    // Single multiply 0x0D x 0xA5, request toggled mid-CALC
    bus8.inputdata_ready = 1'b1;
    tick();
    bus8.inputdata_ready = 1'b0;
    n = 1;
    chk("load_outs", 32'(o8), 32'b10010);
    for (int i = 0; i < 8; i++) begin
      tick();
      n++;
      chk("calc_ctrl", 32'({bus8.loaddata, bus8.shift_en, bus8.busy, bus8.done}), 32'b0110);
      chk("calc_iter", 32'(bus8.iter), 32'(i));
      chk("calc_add_en", 32'(bus8.add_en), 32'(exp_add[i]));
      if (i == 2) bus8.inputdata_ready = 1'b1;
      if (i == 5) bus8.inputdata_ready = 1'b0;
    end
    tick();
    n++;
    chk("done_rise", 32'(o8), 32'b00001);
    chk("req_to_done", 32'(n), 32'd10);
    chk("product_0d_a5", 32'(acc), 32'h0861);
    chk("iter_hold", 32'(bus8.iter), 32'd7);

    // Result held while acknowledge is withheld
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("done_hold", 32'(o8), 32'b00001);
    end
    bus8.result_ack = 1'b1;
    tick();
    bus8.result_ack = 1'b0;
    chk("ack_to_idle", 32'(o8), 32'h0);

    // Back-to-back: 0xFF x 0xFF then 0x03 x 0x05 without an IDLE cycle
    op_a = 8'hFF;
    op_b = 8'hFF;
    bus8.inputdata_ready = 1'b1;
    tick();
    bus8.inputdata_ready = 1'b0;
    n = 1;
    while (!bus8.done && n < 20) begin
      tick();
      n++;
    end
    chk("b2b_first_latency", 32'(n), 32'd10);
    chk("product_ff_ff", 32'(acc), 32'hFE01);
    op_a = 8'h03;
    op_b = 8'h05;
    bus8.result_ack      = 1'b1;
    bus8.inputdata_ready = 1'b1;
    tick();
    bus8.result_ack      = 1'b0;
    bus8.inputdata_ready = 1'b0;
    chk("b2b_load", 32'(o8), 32'b10010);
    n = 1;
    while (!bus8.done && n < 20) begin
      tick();
      n++;
    end
    chk("b2b_second_latency", 32'(n), 32'd10);
    chk("product_03_05", 32'(acc), 32'h000F);
    bus8.result_ack = 1'b1;
    tick();
    bus8.result_ack = 1'b0;
    chk("b2b_idle", 32'(o8), 32'h0);

    // Asynchronous reset in the middle of CALC
    bus8.inputdata_ready = 1'b1;
    tick();
    bus8.inputdata_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("pre_reset_iter", 32'(bus8.iter), 32'd4);
    chk("pre_reset_busy", 32'(bus8.busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("async_reset_outs", 32'(o8), 32'h0);
    chk("async_reset_iter", 32'(bus8.iter), 32'h0);
    tick();
    reset = 1'b1;
    tick();
    chk("post_reset_idle", 32'(o8), 32'h0);

    // Minimum width instance
    bus2.multiplier_lsb  = 1'b1;
    bus2.inputdata_ready = 1'b1;
    tick();
    bus2.inputdata_ready = 1'b0;
    n = 1;
    chk("w2_load", 32'(o2), 32'b10010);
    for (int i = 0; i < 2; i++) begin
      tick();
      n++;
      chk("w2_calc", 32'(o2), 32'b01110);
      chk("w2_iter", 32'(bus2.iter), 32'(i));
    end
    tick();
    n++;
    chk("w2_done", 32'(o2), 32'b00001);
    chk("w2_req_to_done", 32'(n), 32'd4);
    bus2.result_ack = 1'b1;
    tick();
    bus2.result_ack = 1'b0;
    chk("w2_idle", 32'(o2), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_controlunit.md
# mult_controlunit

Sequencing controller for a WIDTH-bit shift-and-add multiplier datapath.
- Takes a start request, commands the operand load, then steps the datapath through exactly WIDTH add/shift iterations.
- Presents the finished result with a done/acknowledge handshake.
- Sits between the input-capture logic that raises `inputdata_ready` and the multiplier's operand/accumulator registers.

## Interface

Parameters:
- WIDTH, default 8: operand width and iteration count. Legal range is WIDTH >= 2.

Ports:
- clk, input, 1: single clock. All state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset (asserted at 0).
- inputdata_ready, input, 1: start request, level-sensitive. Sampled only in IDLE and DONE.
- multiplier_lsb, input, 1: current LSB of the datapath multiplier register.
- result_ack, input, 1: consumer has taken the result. Sampled only in DONE.
- loaddata, output, 1: load operand registers and clear the accumulator.
- add_en, output, 1: accumulator += multiplicand this cycle.
- shift_en, output, 1: shift multiplicand left and multiplier right this cycle.
- busy, output, 1: high in LOAD and CALC.
- done, output, 1: result valid, high in DONE.
- iter, output, $clog2(WIDTH): current iteration index, for debug and datapath use.

## Operation

States are IDLE, LOAD, CALC and DONE.

- **IDLE:** all outputs 0.
  - inputdata_ready=1 -> LOAD.
  - Otherwise stay in IDLE.
- **LOAD:** lasts exactly one cycle.
  - loaddata=1, busy=1.
  - Iteration counter cleared to 0.
  - -> CALC unconditionally.
- **CALC:** busy=1 and shift_en=1 on every cycle.
  - add_en = multiplier_lsb. This is the only Mealy output; all other outputs are Moore.
  - Counter increments each cycle.
  - When iter == WIDTH-1: -> DONE on that edge. Counter then holds its value.
- **DONE:** done=1; all other outputs 0.
  - result_ack=1 and inputdata_ready=1 -> LOAD (back-to-back operation, no IDLE cycle).
  - result_ack=1 only -> IDLE.
  - Otherwise hold in DONE indefinitely.

Additional rules:
- inputdata_ready is ignored in LOAD and CALC. No queuing: a request that is still high when the controller reaches IDLE or DONE is honoured there.
- result_ack outside DONE has no effect.
- Illegal or unused state encodings -> IDLE on the next edge.

## Timing

- **Reset:** asserting reset (0) at any time, including mid-CALC, gives immediately:
  - state = IDLE, iter = 0;
  - loaddata, add_en, shift_en, busy, done all 0.
  
  The first state change after deassertion happens at the first rising edge at which reset=1.
- **Latency:** let inputdata_ready be sampled high at edge k while in IDLE.
  - LOAD occupies cycle k+1.
  - CALC occupies cycles k+2 .. k+WIDTH+1.
  - done rises after edge k+WIDTH+2.
  - Request-to-done is WIDTH+2 cycles.
- **Iteration alignment:** in CALC cycle i (i = 0..WIDTH-1), iter = i and add_en reflects multiplier bit i. The datapath shifts on each of these edges.
- **Throughput:** WIDTH+2 cycles per result when result_ack is returned in the first DONE cycle together with a pending inputdata_ready.

## Structure

- **Package `mult_pkg`:**
  - State typedef: `enum logic [1:0]` with IDLE=2'b00, LOAD=2'b01, CALC=2'b10, DONE=2'b11.
  - Function/constant for the iter width, $clog2(WIDTH).
- **Sub-module `iter_counter`:** parameterised by WIDTH.
  - Inputs: clk, reset, clear, en.
  - Outputs: count, last (count == WIDTH-1).
  - Asynchronous active-low reset to 0.
- **mult_controlunit:**
  - One sequential process for the state register.
  - One combinational process for next state.
  - One combinational process for outputs, with defaults assigned first so there are no latches.

## Test plan

- **Reset:** hold reset=0 for 3 cycles with random inputs -> all outputs 0 and iter=0 throughout. Assert reset mid-CALC at iter=4 -> outputs 0 immediately, without waiting for a clock edge.
- **Single multiply:** WIDTH=8, bench models the datapath with operands 0x0D × 0xA5.
  - add_en over CALC cycles 0..7 = 1,0,1,0,0,1,0,1.
  - done rises exactly 10 cycles after the request edge.
  - Model product = 0x0861.
- **Done hold:** withhold result_ack for 20 cycles -> done stays 1, busy/loaddata/shift_en stay 0. Assert ack -> IDLE next cycle, done=0.
- **Back-to-back:** in the first DONE cycle drive result_ack=1 and inputdata_ready=1 -> LOAD next cycle (loaddata=1), with no IDLE cycle in between.
- **Ignored inputs:**
  - Toggle inputdata_ready during CALC -> no restart, iteration count unchanged.
  - Pulse result_ack in IDLE -> no state change.
- **Minimum width:** WIDTH=2 -> CALC lasts 2 cycles, done 4 cycles after the request edge.
